// File: rtl/adpcm_pkg.sv
// adpcm_pkg: shared G.726 datapath definitions for the ANTILOG stream block.
//   - DQL field positions: [11]=DS, [10:7]=DEX, [6:0]=DMN
//   - DQ output format: {DQS, DQMAG[14:0]}
//   - antilog_calc: combinational log-to-linear conversion of one sample
// Optional feature macro: ANTILOG_SAT_EN (saturate DEX=15 overflow, flag it).
package adpcm_pkg;

  localparam int unsigned DQL_W   = 12;
  localparam int unsigned DS_BIT  = 11;
  localparam int unsigned DEX_MSB = 10;
  localparam int unsigned DEX_LSB = 7;
  localparam int unsigned DMN_W   = 7;
  localparam int unsigned DQ_W    = 16;
  localparam int unsigned DQMAG_W = 15;

  // Width of {DQT,7'b0} shifted left by the largest DEX (15).
  localparam int unsigned SHIFT_W = 30;

  typedef struct packed {
    logic [DQ_W-1:0] dq;
    logic            ovf;
  } antilog_t;

  // DQT = {1,DMN}; MAG16 = ({DQT,7'b0} << DEX) >> 14.
  // DS=1 forces the magnitude to zero while DQS still passes through.
  function automatic antilog_t antilog_calc(input logic [DQL_W-1:0] dql,
                                            input logic             dqs);
    logic [7:0]         dqt;
    logic [SHIFT_W-1:0] shifted;
    antilog_t           res;
`ifdef ANTILOG_SAT_EN
    logic [DQ_W-1:0]    mag16;
`else
    logic [DQMAG_W-1:0] mag15;
`endif
    dqt     = {1'b1, dql[DMN_W-1:0]};
    shifted = {{(SHIFT_W-15){1'b0}}, dqt, 7'b0} << dql[DEX_MSB:DEX_LSB];
    res.ovf = 1'b0;
`ifdef ANTILOG_SAT_EN
    mag16 = DQ_W'(shifted >> 14);
    if (dql[DS_BIT]) begin
      res.dq = {dqs, {DQMAG_W{1'b0}}};
    end else if (mag16[DQ_W-1]) begin
      res.dq  = {dqs, {DQMAG_W{1'b1}}};
      res.ovf = 1'b1;
    end else begin
      res.dq = {dqs, mag16[DQMAG_W-1:0]};
    end
`else
    // Bit-exact G.726: MAG16[15] is simply dropped.
    mag15 = DQMAG_W'(shifted >> 14);
    if (dql[DS_BIT]) begin
      res.dq = {dqs, {DQMAG_W{1'b0}}};
    end else begin
      res.dq = {dqs, mag15};
    end
`endif
    return res;
  endfunction

endpackage

// File: rtl/antilog_pipe_reg.sv
// antilog_pipe_reg: single valid/ready register slice.
//   in_valid/in_ready/in_data   upstream handshake and payload
//   out_valid/out_ready/out_data downstream handshake and payload (registered)
// in_ready = !out_valid || out_ready, so a full slice that is being drained
// accepts new data in the same cycle (no bubble). Payload is loaded only
// when in_valid is high, so idle-cycle garbage never reaches the output.
module antilog_pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/antilog_stream.sv
// antilog_stream: multi-channel pipelined G.726 ANTILOG (DQL,DQS -> DQ).
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_dql, in_dqs, in_ch payload
//   out_valid/out_ready   output handshake; out_dq, out_ch, out_ovf payload
//   sample_cnt            wrapping count of accepted input samples
// Parameters: NUM_CH (channels), PIPE_STAGES (1..3 register slices), CNT_W.
// Optional feature macro: ANTILOG_SAT_EN (DEX=15 saturation + out_ovf);
// with it undefined out_ovf is always 0.
// Arithmetic is combinational ahead of slice 0; the slices form a strict
// FIFO chain, so channel tags keep their order.
module antilog_stream
  import adpcm_pkg::*;
#(
  parameter  int unsigned NUM_CH      = 4,
  parameter  int unsigned PIPE_STAGES = 2,
  parameter  int unsigned CNT_W       = 16,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DQL_W-1:0] in_dql,
  input  logic             in_dqs,
  input  logic [CH_W-1:0]  in_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DQ_W-1:0]  out_dq,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_ovf,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef struct packed {
    logic [DQ_W-1:0] dq;
    logic [CH_W-1:0] ch;
    logic            ovf;
  } stage_t;

  localparam int unsigned STAGE_W = $bits(stage_t);

  if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_depth
    $error("antilog_stream: PIPE_STAGES must be 1..3");
  end

  antilog_t calc;
  stage_t   in_stage;
  stage_t   out_stage;

  always_comb begin
    calc         = antilog_calc(in_dql, in_dqs);
    in_stage     = '0;
    in_stage.dq  = calc.dq;
    in_stage.ch  = in_ch;
    in_stage.ovf = calc.ovf;
  end

  // Each slice owns its own link signals, keeping the ready chain free of
  // self-referencing vectors.
  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    logic   up_valid;
    logic   up_ready;
    stage_t up_data;
    logic   dn_valid;
    logic   dn_ready;
    stage_t dn_data;

    if (k == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_data  = in_stage;
    end else begin : g_chain
      assign up_valid = g_stage[k-1].dn_valid;
      assign up_data  = g_stage[k-1].dn_data;
    end

    if (k == PIPE_STAGES - 1) begin : g_last
      assign dn_ready = out_ready;
    end else begin : g_inner
      assign dn_ready = g_stage[k+1].up_ready;
    end

    antilog_pipe_reg #(
      .W(STAGE_W)
    ) u_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (up_valid),
      .in_ready (up_ready),
      .in_data  (up_data),
      .out_valid(dn_valid),
      .out_ready(dn_ready),
      .out_data (dn_data)
    );
  end

  assign in_ready  = g_stage[0].up_ready;
  assign out_valid = g_stage[PIPE_STAGES-1].dn_valid;
  assign out_stage = g_stage[PIPE_STAGES-1].dn_data;
  assign out_dq    = out_stage.dq;
  assign out_ch    = out_stage.ch;
  assign out_ovf   = out_stage.ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else if (in_valid && in_ready) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

endmodule
